inst_buffer: RTL and testbench

//  Instruction queue between fetch and the dual-issue logic. Fetch pushes 0/1/2 instruction

---
 rtl/inst_buffer_if.sv | 39 +++
 rtl/inst_buffer.sv | 78 +++++++
 tb/tb_inst_buffer.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/inst_buffer_if.sv
// Fetch/issue side bundle of the instruction buffer.
// The slave side is the buffer itself. The master side is the fetch plus issue logic.
interface inst_buffer_if #(
  parameter int WIDTH = 131
);
  logic             branch_flag_i;
  logic [1:0]       fetch_count_i;
  logic [WIDTH-1:0] fetch_inst1_bus_i;
  logic [WIDTH-1:0] fetch_inst2_bus_i;
  logic             fetch_allowin_o;
  logic [1:0]       issue_mode_i;
  logic [1:0]       instbuffer_count_o;
  logic [WIDTH-1:0] inst1_bus_o;
  logic [WIDTH-1:0] inst2_bus_o;

  modport slave (
    input  branch_flag_i,
    input  fetch_count_i,
    input  fetch_inst1_bus_i,
    input  fetch_inst2_bus_i,
    input  issue_mode_i,
    output fetch_allowin_o,
    output instbuffer_count_o,
    output inst1_bus_o,
    output inst2_bus_o
  );

  modport master (
    output branch_flag_i,
    output fetch_count_i,
    output fetch_inst1_bus_i,
    output fetch_inst2_bus_i,
    output issue_mode_i,
    input  fetch_allowin_o,
    input  instbuffer_count_o,
    input  inst1_bus_o,
    input  inst2_bus_o
  );
endinterface

// File: rtl/inst_buffer.sv
// Circular instruction queue between fetch and dual issue.
// It accepts 0-2 pushes and 0-2 pops per cycle, and a branch flush empties it.
module inst_buffer #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 131
) (
  input logic          clk,
  input logic          rst,
  inst_buffer_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] MAX_FILL = (AW+1)'(DEPTH - 2);
  localparam logic [AW:0] TWO = (AW+1)'(2);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    head;
  logic [AW-1:0]    tail;
  logic [AW-1:0]    head_p1;
  logic [AW-1:0]    tail_p1;
  logic [AW:0]      count;
  logic [AW:0]      count_nxt;
  logic [1:0]       push_n;
  logic [1:0]       mode_n;
  logic [1:0]       pop_n;
  logic             flush;

  // Pointers are exactly AW bits wide, so +1 wraps modulo DEPTH.
  assign head_p1 = head + 1'b1;
  assign tail_p1 = tail + 1'b1;
  assign flush   = bus.branch_flag_i;

  assign bus.fetch_allowin_o = (count <= MAX_FILL);

  always_comb begin
    push_n = 2'd0;
    if (bus.fetch_allowin_o && bus.fetch_count_i != 2'd3)
      push_n = bus.fetch_count_i;
  end

  always_comb begin
    mode_n = 2'd0;
    unique case (1'b1)
      bus.issue_mode_i == 2'b01: mode_n = 2'd1;
      bus.issue_mode_i == 2'b10: mode_n = 2'd2;
      default:                   mode_n = 2'd0;
    endcase
  end

  // Clamp over-pop to the entries actually held.
  assign pop_n = (count >= {{(AW-1){1'b0}}, mode_n}) ? mode_n : count[1:0];

  assign count_nxt = count + (AW+1)'(push_n) - (AW+1)'(pop_n);

  assign bus.instbuffer_count_o = (count >= TWO) ? 2'b10 : count[1:0];
  assign bus.inst1_bus_o = (count != '0) ? mem[head] : '0;
  assign bus.inst2_bus_o = (count >= TWO) ? mem[head_p1] : '0;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + AW'(pop_n);
      tail  <= tail + AW'(push_n);
      count <= count_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && !flush) begin
      if (push_n != 2'd0)
        mem[tail] <= bus.fetch_inst1_bus_i;
      if (push_n == 2'd2)
        mem[tail_p1] <= bus.fetch_inst2_bus_i;
    end
  end
endmodule

// File: tb/tb_inst_buffer.sv
// Directed self-checking bench for inst_buffer.
// Each scenario task drives its own stimulus and checks the results inline.
module tb_inst_buffer;
  localparam int W = 131;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  inst_buffer_if #(.WIDTH(W)) bus ();

  inst_buffer #(.DEPTH(16), .WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W-1:0] ent(input int id);
    logic [7:0] b;
    b = 8'(id);
    return {3'(id), {4{b, 24'hC0FFEE}}};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One cycle of stimulus; inputs return to idle afterwards.
  task automatic cyc(input logic [1:0] fc, input int a, input int b,
                     input logic [1:0] mode);
    bus.fetch_count_i     = fc;
    bus.fetch_inst1_bus_i = ent(a);
    bus.fetch_inst2_bus_i = ent(b);
    bus.issue_mode_i      = mode;
    tick();
    bus.fetch_count_i = 2'd0;
    bus.issue_mode_i  = 2'd0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    bus.branch_flag_i = 1'b0;
    bus.fetch_count_i = 2'd0;
    bus.issue_mode_i  = 2'd0;
    bus.fetch_inst1_bus_i = '0;
    bus.fetch_inst2_bus_i = '0;
    do_reset();
    tick();
    checks++;
    if (bus.instbuffer_count_o !== 2'b00) begin
      errors++;
      $display("FAIL reset_count: got %b exp 00", bus.instbuffer_count_o);
    end
    checks++;
    if (bus.inst1_bus_o !== '0) begin
      errors++;
      $display("FAIL reset_inst1: got %h exp 0", bus.inst1_bus_o);
    end
    checks++;
    if (bus.inst2_bus_o !== '0) begin
      errors++;
      $display("FAIL reset_inst2: got %h exp 0", bus.inst2_bus_o);
    end
    checks++;
    if (bus.fetch_allowin_o !== 1'b1) begin
      errors++;
      $display("FAIL reset_allowin: got %b exp 1", bus.fetch_allowin_o);
    end
  endtask

  task automatic test_push_pop();
    do_reset();
    cyc(2'd2, 1, 2, 2'b00);
    checks++;
    if (bus.instbuffer_count_o !== 2'b10) begin
      errors++;
      $display("FAIL pp_count: got %b exp 10", bus.instbuffer_count_o);
    end
    checks++;
    if (bus.inst1_bus_o !== ent(1)) begin
      errors++;
      $display("FAIL pp_inst1: got %h exp %h", bus.inst1_bus_o, ent(1));
    end
    checks++;
    if (bus.inst2_bus_o !== ent(2)) begin
      errors++;
      $display("FAIL pp_inst2: got %h exp %h", bus.inst2_bus_o, ent(2));
    end
    cyc(2'd0, 0, 0, 2'b10);
    checks++;
    if (bus.instbuffer_count_o !== 2'b00 || bus.inst1_bus_o !== '0) begin
      errors++;
      $display("FAIL pp_double: got cnt %b inst1 %h exp 00/0",
               bus.instbuffer_count_o, bus.inst1_bus_o);
    end
  endtask

  task automatic test_fill();
    do_reset();
    for (int i = 0; i < 7; i++) cyc(2'd2, 10 + 2*i, 11 + 2*i, 2'b00);
    checks++;
    if (bus.fetch_allowin_o !== 1'b1 || bus.inst1_bus_o !== ent(10)) begin
      errors++;
      $display("FAIL fill14: got allow %b inst1 %h exp 1/%h",
               bus.fetch_allowin_o, bus.inst1_bus_o, ent(10));
    end
    cyc(2'd2, 24, 25, 2'b00);
    checks++;
    if (bus.fetch_allowin_o !== 1'b0) begin
      errors++;
      $display("FAIL fill16_allow: got %b exp 0", bus.fetch_allowin_o);
    end
    cyc(2'd2, 90, 91, 2'b00);
    checks++;
    if (bus.fetch_allowin_o !== 1'b0 || bus.instbuffer_count_o !== 2'b10) begin
      errors++;
      $display("FAIL full_push: got allow %b cnt %b exp 0/10",
               bus.fetch_allowin_o, bus.instbuffer_count_o);
    end
    cyc(2'd0, 0, 0, 2'b01);
    checks++;
    if (bus.fetch_allowin_o !== 1'b0 || bus.inst1_bus_o !== ent(11)) begin
      errors++;
      $display("FAIL fill15: got allow %b inst1 %h exp 0/%h",
               bus.fetch_allowin_o, bus.inst1_bus_o, ent(11));
    end
    for (int k = 0; k < 7; k++) begin
      checks++;
      if (bus.inst1_bus_o !== ent(11 + 2*k) || bus.inst2_bus_o !== ent(12 + 2*k)) begin
        errors++;
        $display("FAIL drain_%0d: got %h/%h exp %h/%h", k,
                 bus.inst1_bus_o, bus.inst2_bus_o, ent(11 + 2*k), ent(12 + 2*k));
      end
      cyc(2'd0, 0, 0, 2'b10);
    end
    checks++;
    if (bus.instbuffer_count_o !== 2'b01 || bus.inst1_bus_o !== ent(25) ||
        bus.inst2_bus_o !== '0) begin
      errors++;
      $display("FAIL drain_last: got cnt %b %h/%h exp 01/%h/0",
               bus.instbuffer_count_o, bus.inst1_bus_o, bus.inst2_bus_o, ent(25));
    end
    cyc(2'd0, 0, 0, 2'b01);
    checks++;
    if (bus.instbuffer_count_o !== 2'b00) begin
      errors++;
      $display("FAIL drain_empty: got %b exp 00", bus.instbuffer_count_o);
    end
  endtask

  task automatic test_simul();
    do_reset();
    cyc(2'd2, 40, 41, 2'b00);
    cyc(2'd1, 42, 0, 2'b00);
    cyc(2'd2, 43, 44, 2'b01);
    checks++;
    if (bus.inst1_bus_o !== ent(41) || bus.inst2_bus_o !== ent(42)) begin
      errors++;
      $display("FAIL simul_pair: got %h/%h exp %h/%h",
               bus.inst1_bus_o, bus.inst2_bus_o, ent(41), ent(42));
    end
    cyc(2'd0, 0, 0, 2'b10);
    checks++;
    if (bus.instbuffer_count_o !== 2'b10 || bus.inst1_bus_o !== ent(43)) begin
      errors++;
      $display("FAIL simul_cnt4: got cnt %b inst1 %h exp 10/%h",
               bus.instbuffer_count_o, bus.inst1_bus_o, ent(43));
    end
    cyc(2'd0, 0, 0, 2'b10);
    cyc(2'd0, 0, 0, 2'b01);
    checks++;
    if (bus.instbuffer_count_o !== 2'b00) begin
      errors++;
      $display("FAIL clamp_empty: got %b exp 00", bus.instbuffer_count_o);
    end
    cyc(2'd1, 45, 0, 2'b00);
    checks++;
    if (bus.instbuffer_count_o !== 2'b01 || bus.inst1_bus_o !== ent(45) ||
        bus.inst2_bus_o !== '0) begin
      errors++;
      $display("FAIL clamp_push1: got cnt %b %h/%h exp 01/%h/0",
               bus.instbuffer_count_o, bus.inst1_bus_o, bus.inst2_bus_o, ent(45));
    end
    cyc(2'd0, 0, 0, 2'b10);
    checks++;
    if (bus.instbuffer_count_o !== 2'b00 || bus.fetch_allowin_o !== 1'b1) begin
      errors++;
      $display("FAIL clamp_over: got cnt %b allow %b exp 00/1",
               bus.instbuffer_count_o, bus.fetch_allowin_o);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 0; i < 7; i++) cyc(2'd2, 50 + 2*i, 51 + 2*i, 2'b00);
    for (int i = 0; i < 7; i++) cyc(2'd0, 0, 0, 2'b10);
    cyc(2'd1, 64, 0, 2'b00);
    cyc(2'd0, 0, 0, 2'b01);
    cyc(2'd2, 70, 71, 2'b00);
    checks++;
    if (bus.inst1_bus_o !== ent(70) || bus.inst2_bus_o !== ent(71)) begin
      errors++;
      $display("FAIL wrap_pair: got %h/%h exp %h/%h",
               bus.inst1_bus_o, bus.inst2_bus_o, ent(70), ent(71));
    end
    cyc(2'd0, 0, 0, 2'b10);
    cyc(2'd2, 72, 73, 2'b00);
    checks++;
    if (bus.inst1_bus_o !== ent(72) || bus.inst2_bus_o !== ent(73)) begin
      errors++;
      $display("FAIL wrap_head1: got %h/%h exp %h/%h",
               bus.inst1_bus_o, bus.inst2_bus_o, ent(72), ent(73));
    end
  endtask

  task automatic test_flush();
    do_reset();
    cyc(2'd2, 80, 81, 2'b00);
    cyc(2'd2, 82, 83, 2'b00);
    cyc(2'd1, 84, 0, 2'b00);
    bus.branch_flag_i = 1'b1;
    cyc(2'd2, 85, 86, 2'b01);
    bus.branch_flag_i = 1'b0;
    checks++;
    if (bus.instbuffer_count_o !== 2'b00 || bus.inst1_bus_o !== '0 ||
        bus.inst2_bus_o !== '0 || bus.fetch_allowin_o !== 1'b1) begin
      errors++;
      $display("FAIL flush_empty: got cnt %b %h/%h allow %b exp 00/0/0/1",
               bus.instbuffer_count_o, bus.inst1_bus_o, bus.inst2_bus_o,
               bus.fetch_allowin_o);
    end
    cyc(2'd1, 87, 0, 2'b00);
    checks++;
    if (bus.instbuffer_count_o !== 2'b01 || bus.inst1_bus_o !== ent(87) ||
        bus.inst2_bus_o !== '0) begin
      errors++;
      $display("FAIL flush_after: got cnt %b %h/%h exp 01/%h/0",
               bus.instbuffer_count_o, bus.inst1_bus_o, bus.inst2_bus_o, ent(87));
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    test_reset();
    test_push_pop();
    test_fill();
    test_simul();
    test_wrap();
    test_flush();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
